gf16_root_inv: RTL and testbench
================================

// Module: gf16_root_inv
// PURPOSE
//  Iterative GF(2^4) square-root / inverse unit; the inverse direction of the field squarer.
//  sqrt(a) = a^8 (three squarings); inv(a) = a^14 = a^2*a^4*a^8 (shared squarer + multiplier).
//  Sits beside the squarer/multiplier blocks in the field-arithmetic datapath.
//  Valid/ready handshake on both sides; one operation in flight.
// PARAMETERS
//  POLY  4'b0011  low coefficients of the monic reduction polynomial: x^4 = POLY (default x^4+x+1)
// PORTS
//  clk        in   1  single clock; all state changes on rising edge
//  rst        in   1  synchronous, active-high reset
//  in_valid   in   1  request valid
//  in_ready   out  1  unit can accept a request (high only in IDLE)
//  in_op      in   1  0 = square root, 1 = inverse
//  in_a       in   4  operand, polynomial basis, bit i = coeff of x^i
//  out_valid  out  1  result valid; held until out_ready
//  out_ready  in   1  consumer accepts result
//  out_z      out  4  result, stable while out_valid
// BEHAVIOUR
//  Reset: state=IDLE, in_ready=1 (combinational from state), out_valid=0, out_z=0, cnt=0, r=0, acc=0.
//  Reset mid-operation aborts: in-flight request and any pending result are discarded.
//  Registers: r[3:0], acc[3:0], op, cnt[1:0]. Squarer: r^2 mod P. Multiplier: acc*(r^2) mod P.
//  Reduction: 7-bit carry-less product folded from bit 6 down to bit 4 using x^4 = POLY.
//  FSM:
//   IDLE: in_ready=1. On in_valid: r<=in_a, acc<=4'h1, op<=in_op, cnt<=0 -> CALC.
//   CALC: in_ready=0. Each cycle: r<=r^2, acc<=acc*r^2, cnt<=cnt+1.
//         On cnt==2 (third step): out_z<=(op ? acc*r^2 : r^2), out_valid<=1 -> DONE.
//   DONE: out_valid=1, out_z held. On out_ready: out_valid<=0 -> IDLE. in_ready=0 in DONE.
//  Step values: r = a^2, a^4, a^8; acc = a^2, a^6, a^14.
//  Latency: accept edge T -> out_valid high after edge T+3; throughput 1 result per 5 cycles
//   (when out_ready is held high).
//  in_a/in_op are sampled only on the accept edge; changes afterwards are ignored.
//  in_valid outside IDLE: ignored (not accepted, not queued).
//  Zero operand: sqrt(0)=0, inv(0)=0 (natural a^14 result); no exception in the base build.
//  out_ready while out_valid=0: ignored.
//  All arithmetic is XOR/AND over GF(2); no integer carries anywhere.
// CONFIGURATION
//  GF16_ROOT_INV_ZERO_FLAG_EN defined: adds port out_zero_err (out, 1).
//   Set on the same edge out_valid rises when op==1 and the captured operand == 0.
//   Held with out_z; cleared on reset and on the result handshake. out_z is still 0.
//  Not defined: port absent; inverse of 0 returns 0 silently; no other behaviour differs.
// TESTING
//  1. sqrt a=4'h2 (in_op=0) -> out_z=4'h5 after 3 CALC cycles; check 5^2 = 2 via squarer model.
//  2. inv a=4'h2 -> out_z=4'h9; inv a=4'h3 -> out_z=4'hE; inv a=4'h1 -> out_z=4'h1.
//  3. sqrt a=4'h3 -> 4'h4; exhaustive sweep of all 16 operands x both ops vs reference model;
//     check sqrt(a)^2==a and a*inv(a)==1 for a!=0.
//  4. Backpressure: hold out_ready=0 for 10 cycles in DONE -> out_valid/out_z stable,
//     in_ready=0, a second in_valid pulse is not accepted; release -> IDLE next cycle.
//  5. rst asserted in cycle 2 of CALC -> next cycle IDLE, out_valid=0, out_z=0,
//     no result ever emitted for the aborted request.
//  6. inv a=4'h0 -> out_z=0; with GF16_ROOT_INV_ZERO_FLAG_EN out_zero_err=1;
//     sqrt a=0 -> out_zero_err=0.

Source files
------------

// File: rtl/gf16_root_inv.sv
// Iterative GF(2^4) square root (a^8) / inverse (a^14) unit with valid/ready handshakes.
// Optional zero-operand inverse flag: define GF16_ROOT_INV_ZERO_FLAG_EN to add out_zero_err_o.
module gf16_root_inv #(
    parameter logic [3:0] POLY = 4'b0011
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       in_valid_i,
    output logic       in_ready_o,
    input  logic       in_op_i,
    input  logic [3:0] in_a_i,
    output logic       out_valid_o,
    input  logic       out_ready_i,
`ifdef GF16_ROOT_INV_ZERO_FLAG_EN
    output logic       out_zero_err_o,
`endif
    output logic [3:0] out_z_o
);

    // state | meaning
    // IDLE  | waiting for a request, in_ready high
    // CALC  | three square/multiply steps, cnt counts them
    // DONE  | result presented until out_ready
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0] state_q, state_d;
    logic [3:0] r_q, r_d;
    logic [3:0] acc_q, acc_d;
    logic       op_q, op_d;
    logic [1:0] cnt_q, cnt_d;
    logic [3:0] out_z_q, out_z_d;
    logic [3:0] sq;
    logic [3:0] prod;

    // Carry-less product, then fold x^6..x^4 back using x^4 = POLY.
    function automatic logic [3:0] gf_mul(input logic [3:0] x, input logic [3:0] y);
        logic [6:0] p;
        p = '0;
        for (int i = 0; i < 4; i++) begin
            if (y[i]) p = p ^ (7'(x) << i);
        end
        for (int i = 6; i >= 4; i--) begin
            if (p[i]) begin
                p[i]         = 1'b0;
                p[i-4 +: 4]  = p[i-4 +: 4] ^ POLY;
            end
        end
        return p[3:0];
    endfunction

    assign sq   = gf_mul(r_q, r_q);
    assign prod = gf_mul(acc_q, sq);

    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        acc_d   = acc_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        out_z_d = out_z_q;
        case (state_q)
            IDLE: begin
                if (in_valid_i) begin
                    r_d     = in_a_i;
                    acc_d   = 4'h1;
                    op_d    = in_op_i;
                    cnt_d   = 2'd0;
                    state_d = CALC;
                end
            end
            CALC: begin
                r_d   = sq;
                acc_d = prod;
                cnt_d = cnt_q + 2'd1;
                if (cnt_q == 2'd2) begin
                    out_z_d = op_q ? prod : sq;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            r_q     <= '0;
            acc_q   <= '0;
            op_q    <= 1'b0;
            cnt_q   <= '0;
            out_z_q <= '0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            acc_q   <= acc_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            out_z_q <= out_z_d;
        end
    end

`ifdef GF16_ROOT_INV_ZERO_FLAG_EN
    logic zero_err_q, zero_err_d;

    // Squaring maps zero to zero only, so r is zero at the last step iff the operand was.
    always_comb begin
        zero_err_d = zero_err_q;
        if (state_q == CALC && cnt_q == 2'd2) zero_err_d = op_q && (r_q == 4'h0);
        else if (state_q == DONE && out_ready_i) zero_err_d = 1'b0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) zero_err_q <= 1'b0;
        else       zero_err_q <= zero_err_d;
    end

    assign out_zero_err_o = zero_err_q;
`endif

    assign in_ready_o  = (state_q == IDLE);
    assign out_valid_o = (state_q == DONE);
    assign out_z_o     = out_z_q;

endmodule

// File: tb/tb_gf16_root_inv.sv
// Directed and sweep bench for gf16_root_inv; reference built from a power table of x mod x^4+x+1.
module tb_gf16_root_inv;
    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic       in_valid_i = 1'b0;
    logic       in_ready_o;
    logic       in_op_i = 1'b0;
    logic [3:0] in_a_i = 4'h0;
    logic       out_valid_o;
    logic       out_ready_i = 1'b0;
    logic [3:0] out_z_o;
`ifdef GF16_ROOT_INV_ZERO_FLAG_EN
    logic       out_zero_err_o;
`endif

    int total = 0;
    int bad   = 0;

    gf16_root_inv dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .in_op_i     (in_op_i),
        .in_a_i      (in_a_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
`ifdef GF16_ROOT_INV_ZERO_FLAG_EN
        .out_zero_err_o (out_zero_err_o),
`endif
        .out_z_o     (out_z_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [3:0] gexp(input int k);
        case (k % 15)
            0: return 4'h1;  1: return 4'h2;  2: return 4'h4;  3: return 4'h8;
            4: return 4'h3;  5: return 4'h6;  6: return 4'hC;  7: return 4'hB;
            8: return 4'h5;  9: return 4'hA; 10: return 4'h7; 11: return 4'hE;
            12: return 4'hF; 13: return 4'hD; default: return 4'h9;
        endcase
    endfunction

    function automatic int glog(input logic [3:0] a);
        for (int k = 0; k < 15; k++) if (gexp(k) == a) return k;
        return 0;
    endfunction

    function automatic logic [3:0] ref_mul(input logic [3:0] a, input logic [3:0] b);
        if (a == 4'h0 || b == 4'h0) return 4'h0;
        return gexp(glog(a) + glog(b));
    endfunction

    function automatic logic [3:0] ref_op(input logic op, input logic [3:0] a);
        if (a == 4'h0) return 4'h0;
        return op ? gexp(glog(a) * 14) : gexp(glog(a) * 8);
    endfunction

    // Stimulus only: issue one request, return result, latency (-1 on timeout) and flag.
    task automatic run_op(input logic op, input logic [3:0] a,
                          output logic [3:0] z, output int lat, output logic zf);
        int n = 0;
        z = 4'hx; zf = 1'b0; lat = -1;
        while (!in_ready_o && n < 20) begin @(posedge clk_i); #1; n++; end
        if (!in_ready_o) return;
        in_valid_i = 1'b1; in_op_i = op; in_a_i = a;
        @(posedge clk_i); #1;
        in_valid_i = 1'b0; in_a_i = ~a; in_op_i = ~op;
        n = 0;
        while (n < 20) begin
            @(posedge clk_i); #1; n++;
            if (out_valid_o) break;
        end
        if (!out_valid_o) return;
        lat = n;
        z = out_z_o;
`ifdef GF16_ROOT_INV_ZERO_FLAG_EN
        zf = out_zero_err_o;
`endif
        out_ready_i = 1'b1;
        @(posedge clk_i); #1;
        out_ready_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;
        total++; if (in_ready_o !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready_o); end
        total++; if (out_valid_o !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid_o); end
        total++; if (out_z_o !== 4'h0) begin bad++; $display("FAIL reset_out_z got=%h want=0", out_z_o); end
        rst_i = 1'b0;
    endtask

    task automatic test_directed();
        logic       ops [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [3:0] as  [5] = '{4'h2, 4'h2, 4'h3, 4'h1, 4'h3};
        logic [3:0] exs [5] = '{4'h5, 4'h9, 4'hE, 4'h1, 4'h4};
        logic [3:0] z; int lat; logic zf;
        for (int i = 0; i < 5; i++) begin
            run_op(ops[i], as[i], z, lat, zf);
            total++; if (lat != 3) begin bad++; $display("FAIL dir_latency[%0d] got=%0d want=3", i, lat); end
            total++; if (z !== exs[i]) begin bad++; $display("FAIL dir_z[%0d] op=%b a=%h got=%h want=%h", i, ops[i], as[i], z, exs[i]); end
            if (i == 0) begin
                total++; if (ref_mul(z, z) !== as[i]) begin bad++; $display("FAIL dir_sqrt_square got=%h want=%h", ref_mul(z, z), as[i]); end
            end
        end
    endtask

    task automatic test_sweep();
        logic [3:0] z; int lat; logic zf;
        for (int op = 0; op < 2; op++) begin
            for (int a = 0; a < 16; a++) begin
                run_op(op[0], a[3:0], z, lat, zf);
                total++;
                if (lat != 3 || z !== ref_op(op[0], a[3:0])) begin
                    bad++; $display("FAIL sweep op=%0d a=%h got=%h lat=%0d want=%h", op, a, z, lat, ref_op(op[0], a[3:0]));
                end
                if (op == 0) begin
                    total++; if (ref_mul(z, z) !== a[3:0]) begin bad++; $display("FAIL sweep_sqrt_sq a=%h got=%h", a, ref_mul(z, z)); end
                end else if (a != 0) begin
                    total++; if (ref_mul(a[3:0], z) !== 4'h1) begin bad++; $display("FAIL sweep_inv_prod a=%h got=%h want=1", a, ref_mul(a[3:0], z)); end
                end
            end
        end
    endtask

    task automatic test_backpressure();
        int n = 0;
        in_valid_i = 1'b1; in_op_i = 1'b0; in_a_i = 4'h6;
        @(posedge clk_i); #1;
        in_valid_i = 1'b0;
        while (!out_valid_o && n < 20) begin @(posedge clk_i); #1; n++; end
        total++; if (!out_valid_o) begin bad++; $display("FAIL bp_timeout got=0 want=1"); end
        for (int i = 0; i < 10; i++) begin
            in_valid_i = (i == 4); in_op_i = 1'b1; in_a_i = 4'h7;
            total++;
            if (out_valid_o !== 1'b1 || out_z_o !== 4'h7 || in_ready_o !== 1'b0) begin
                bad++; $display("FAIL bp_hold[%0d] valid=%b z=%h ready=%b want 1/7/0", i, out_valid_o, out_z_o, in_ready_o);
            end
            @(posedge clk_i); #1;
        end
        in_valid_i = 1'b0;
        out_ready_i = 1'b1;
        @(posedge clk_i); #1;
        out_ready_i = 1'b0;
        total++; if (in_ready_o !== 1'b1 || out_valid_o !== 1'b0) begin bad++; $display("FAIL bp_release ready=%b valid=%b want 1/0", in_ready_o, out_valid_o); end
        for (int i = 0; i < 6; i++) begin
            @(posedge clk_i); #1;
            total++; if (out_valid_o !== 1'b0) begin bad++; $display("FAIL bp_no_queue[%0d] got=%b want=0", i, out_valid_o); end
        end
    endtask

    task automatic test_reset_mid();
        in_valid_i = 1'b1; in_op_i = 1'b1; in_a_i = 4'hB;
        @(posedge clk_i); #1;
        in_valid_i = 1'b0;
        @(posedge clk_i); #1;
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        total++;
        if (in_ready_o !== 1'b1 || out_valid_o !== 1'b0 || out_z_o !== 4'h0) begin
            bad++; $display("FAIL rst_mid ready=%b valid=%b z=%h want 1/0/0", in_ready_o, out_valid_o, out_z_o);
        end
        for (int i = 0; i < 8; i++) begin
            @(posedge clk_i); #1;
            total++; if (out_valid_o !== 1'b0) begin bad++; $display("FAIL rst_mid_no_result[%0d] got=%b want=0", i, out_valid_o); end
        end
    endtask

    task automatic test_zero();
        logic [3:0] z; int lat; logic zf;
        run_op(1'b1, 4'h0, z, lat, zf);
        total++; if (lat != 3 || z !== 4'h0) begin bad++; $display("FAIL zero_inv got=%h lat=%0d want=0", z, lat); end
`ifdef GF16_ROOT_INV_ZERO_FLAG_EN
        total++; if (zf !== 1'b1) begin bad++; $display("FAIL zero_inv_flag got=%b want=1", zf); end
        total++; if (out_zero_err_o !== 1'b0) begin bad++; $display("FAIL zero_flag_clear got=%b want=0", out_zero_err_o); end
`endif
        run_op(1'b0, 4'h0, z, lat, zf);
        total++; if (lat != 3 || z !== 4'h0) begin bad++; $display("FAIL zero_sqrt got=%h lat=%0d want=0", z, lat); end
`ifdef GF16_ROOT_INV_ZERO_FLAG_EN
        total++; if (zf !== 1'b0) begin bad++; $display("FAIL zero_sqrt_flag got=%b want=0", zf); end
`endif
    endtask

    initial begin
        test_reset();
        test_directed();
        test_sweep();
        test_backpressure();
        test_reset_mid();
        test_zero();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
